// File: rtl/sha1_pkg.sv
// SHA-1 shared types, constants and helpers.
// Used by the schedule expander and its word-expansion slice.
package sha1_pkg;

  typedef logic [31:0]       word_t;
  typedef logic [15:0][31:0] block_t;
  typedef logic [79:0][31:0] sched_t;

  localparam word_t H0 = 32'h67452301;
  localparam word_t H1 = 32'hEFCDAB89;
  localparam word_t H2 = 32'h98BADCFE;
  localparam word_t H3 = 32'h10325476;
  localparam word_t H4 = 32'hC3D2E1F0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  function automatic word_t rotl(input word_t x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/sha1_wexp_word.sv
// One SHA-1 schedule word:
// W[t] = ROTL1(W[t-3] ^ W[t-8] ^ W[t-14] ^ W[t-16]).
module sha1_wexp_word
  import sha1_pkg::*;
(
  input  word_t w3,
  input  word_t w8,
  input  word_t w14,
  input  word_t w16,
  output word_t w
);

  assign w = rotl(w3 ^ w8 ^ w14 ^ w16, 5'd1);

endmodule

// File: rtl/sha1_schedule.sv
// SHA-1 message-schedule expander: 16 words in, 80 words out,
// chaining values passed through, valid/ready on both sides.
module sha1_schedule
  import sha1_pkg::*;
#(
  parameter int WORDS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              o_tready_in,
  input  logic              i_tvalid_in,
  input  logic [15:0][31:0] i_block,
  input  logic [31:0]       i_A,
  input  logic [31:0]       i_B,
  input  logic [31:0]       i_C,
  input  logic [31:0]       i_D,
  input  logic [31:0]       i_E,
  input  logic              i_tready_out,
  output logic              o_tvalid_out,
  output logic [79:0][31:0] o_data,
  output logic [31:0]       o_A,
  output logic [31:0]       o_B,
  output logic [31:0]       o_C,
  output logic [31:0]       o_D,
  output logic [31:0]       o_E
);

  localparam int N = WORDS_PER_CYCLE;

  if (N != 1 && N != 2 && N != 4) begin : g_bad_n
    $fatal(1, "sha1_schedule: WORDS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t     state;
  logic [6:0] cnt;
  word_t      nw [N];

  // Slot 3 depends on slot 0 of the same cycle, which is not yet stored.
  for (genvar g = 0; g < N; g++) begin : g_word
    logic [6:0] t;
    word_t      w3;

    assign t = cnt + 7'(g);

    if (g == 3) begin : g_chain
      assign w3 = nw[0];
    end else begin : g_reg
      assign w3 = o_data[t - 7'd3];
    end

    sha1_wexp_word u_wexp (
      .w3  (w3),
      .w8  (o_data[t - 7'd8]),
      .w14 (o_data[t - 7'd14]),
      .w16 (o_data[t - 7'd16]),
      .w   (nw[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      o_tready_in  <= 1'b1;
      o_tvalid_out <= 1'b0;
      cnt          <= 7'd16;
      o_data       <= '0;
      o_A          <= '0;
      o_B          <= '0;
      o_C          <= '0;
      o_D          <= '0;
      o_E          <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_tvalid_in && o_tready_in) begin
            o_data[15:0] <= i_block;
            o_A          <= i_A;
            o_B          <= i_B;
            o_C          <= i_C;
            o_D          <= i_D;
            o_E          <= i_E;
            cnt          <= 7'd16;
            o_tready_in  <= 1'b0;
            state        <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          for (int i = 0; i < N; i++) begin
            o_data[cnt + 7'(i)] <= nw[i];
          end
          cnt <= cnt + 7'(N);
          if (cnt + 7'(N) == 7'd80) begin
            o_tvalid_out <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_tready_out) begin
            o_tvalid_out <= 1'b0;
            o_tready_in  <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_schedule.sv
// Bench for sha1_schedule at WORDS_PER_CYCLE = 1, 2 and 4,
// scoreboarded against a software schedule model.
module tb_sha1_schedule;
  import sha1_pkg::*;

  typedef struct {
    sched_t w;
    word_t  a, b, c, d, e;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  block_t blk;
  word_t  ia, ib, ic, id, ie;
  logic   tv_in  [3];
  logic   tr_out [3];
  logic   tr_in  [3];
  logic   tv_out [3];
  sched_t od     [3];
  word_t  oa [3], ob [3], oc [3], odd [3], oe [3];

  exp_t   q[$];
  int     checks = 0;
  int     fails  = 0;
  int     sel    = 0;
  int     cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sha1_schedule #(.WORDS_PER_CYCLE(1)) u_n1 (
    .clk(clk), .reset(reset), .o_tready_in(tr_in[0]), .i_tvalid_in(tv_in[0]),
    .i_block(blk), .i_A(ia), .i_B(ib), .i_C(ic), .i_D(id), .i_E(ie),
    .i_tready_out(tr_out[0]), .o_tvalid_out(tv_out[0]), .o_data(od[0]),
    .o_A(oa[0]), .o_B(ob[0]), .o_C(oc[0]), .o_D(odd[0]), .o_E(oe[0])
  );

  sha1_schedule #(.WORDS_PER_CYCLE(2)) u_n2 (
    .clk(clk), .reset(reset), .o_tready_in(tr_in[1]), .i_tvalid_in(tv_in[1]),
    .i_block(blk), .i_A(ia), .i_B(ib), .i_C(ic), .i_D(id), .i_E(ie),
    .i_tready_out(tr_out[1]), .o_tvalid_out(tv_out[1]), .o_data(od[1]),
    .o_A(oa[1]), .o_B(ob[1]), .o_C(oc[1]), .o_D(odd[1]), .o_E(oe[1])
  );

  sha1_schedule #(.WORDS_PER_CYCLE(4)) u_n4 (
    .clk(clk), .reset(reset), .o_tready_in(tr_in[2]), .i_tvalid_in(tv_in[2]),
    .i_block(blk), .i_A(ia), .i_B(ib), .i_C(ic), .i_D(id), .i_E(ie),
    .i_tready_out(tr_out[2]), .o_tvalid_out(tv_out[2]), .o_data(od[2]),
    .o_A(oa[2]), .o_B(ob[2]), .o_C(oc[2]), .o_D(odd[2]), .o_E(oe[2])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, sel, got, exp);
    end
  endtask

  task automatic cmp_sched(input string tag, input sched_t got,
                           input sched_t exp);
    int idx = 0;
    for (int t = 79; t >= 0; t--)
      if (got[t] !== exp[t]) idx = t;
    check($sformatf("%s.W%0d", tag, idx), got[idx], exp[idx]);
  endtask

  function automatic sched_t expand(input block_t b);
    sched_t w;
    word_t  x;
    w = '0;
    for (int j = 0; j < 16; j++) w[j] = b[j];
    for (int t = 16; t < 80; t++) begin
      x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {x[30:0], x[31]};
    end
    return w;
  endfunction

  function automatic block_t rand_block();
    block_t b;
    for (int j = 0; j < 16; j++) b[j] = $urandom;
    return b;
  endfunction

  always @(negedge clk) begin
    if (!reset && tv_out[sel] && tr_out[sel]) begin
      exp_t e;
      check("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp_sched("sched", od[sel], e.w);
        check("A", oa[sel], e.a);
        check("B", ob[sel], e.b);
        check("C", oc[sel], e.c);
        check("D", odd[sel], e.d);
        check("E", oe[sel], e.e);
      end
    end
  end

  task automatic send(input block_t b, input word_t a, input word_t bb,
                      input word_t c, input word_t d, input word_t e,
                      input bit hold, output int acc);
    exp_t x;
    logic rb;
    bit   ok = 0;
    blk = b; ia = a; ib = bb; ic = c; id = d; ie = e;
    tv_in[sel] = 1'b1;
    x.w = expand(b);
    x.a = a; x.b = bb; x.c = c; x.d = d; x.e = e;
    q.push_back(x);
    acc = cyc;
    for (int i = 0; i < 400 && !ok; i++) begin
      rb = tr_in[sel];
      @(posedge clk);
      #1;
      if (rb) begin
        ok  = 1;
        acc = cyc;
      end
    end
    check("accept", 32'(ok), 32'd1);
    if (!hold) tv_in[sel] = 1'b0;
  endtask

  task automatic rand_send(input bit hold, output int acc);
    send(rand_block(), $urandom, $urandom, $urandom, $urandom, $urandom,
         hold, acc);
  endtask

  task automatic wait_valid(output int at);
    bit ok = 0;
    at = cyc;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (tv_out[sel]) begin
        ok = 1;
        at = cyc;
      end
    end
    check("valid_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (tr_in[sel]) ok = 1;
    end
    check("back_idle", 32'(ok), 32'd1);
  endtask

  initial begin
    block_t abc;
    sched_t zero;
    sched_t saved;
    int     acc, at, prev, lat;
    int     bad_d, bad_v, bad_r;

    abc = '0;
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    zero = '0;
    blk = '0;
    {ia, ib, ic, id, ie} = '0;
    for (int k = 0; k < 3; k++) begin
      tv_in[k]  = 1'b0;
      tr_out[k] = 1'b1;
    end

    for (int k = 0; k < 3; k++) begin
      sel = k;
      lat = 64 >> k;

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      check("rst_tready", 32'(tr_in[k]), 32'd1);
      check("rst_tvalid", 32'(tv_out[k]), 32'd0);
      cmp_sched("rst_data", od[k], zero);
      check("rst_A", oa[k], 32'd0);

      // "abc" block
      send(abc, H0, H1, H2, H3, H4, 1'b0, acc);
      wait_valid(at);
      check("latency", 32'(at - acc), 32'(lat));
      check("W16", od[k][16], 32'hC2C4C700);
      check("W17", od[k][17], 32'h00000000);
      check("W18", od[k][18], 32'h00000030);
      check("W19", od[k][19], 32'h85898E01);
      wait_idle();

      // backpressure with ignored input pulses
      tr_out[k] = 1'b0;
      rand_send(1'b0, acc);
      wait_valid(at);
      saved = od[k];
      bad_d = 0; bad_v = 0; bad_r = 0;
      for (int i = 0; i < 20; i++) begin
        tv_in[k] = i[0];
        blk = rand_block();
        ia  = $urandom;
        @(posedge clk);
        #1;
        if (od[k] !== saved) bad_d++;
        if (tv_out[k] !== 1'b1) bad_v++;
        if (tr_in[k] !== 1'b0) bad_r++;
      end
      tv_in[k] = 1'b0;
      check("bp_data_stable", 32'(bad_d), 32'd0);
      check("bp_valid_held", 32'(bad_v), 32'd0);
      check("bp_tready_low", 32'(bad_r), 32'd0);
      tr_out[k] = 1'b1;
      wait_idle();

      // back-to-back with valid held high
      prev = 0;
      for (int i = 0; i < 10; i++) begin
        rand_send(1'b1, acc);
        if (i > 0) check("spacing", 32'(acc - prev), 32'(lat + 2));
        prev = acc;
      end
      tv_in[k] = 1'b0;
      wait_valid(at);
      wait_idle();

      // reset in the middle of EXPAND
      rand_send(1'b0, acc);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      check("mid_rst_tvalid", 32'(tv_out[k]), 32'd0);
      check("mid_rst_tready", 32'(tr_in[k]), 32'd1);
      cmp_sched("mid_rst_data", od[k], zero);
      rand_send(1'b0, acc);
      wait_valid(at);
      check("post_rst_latency", 32'(at - acc), 32'(lat));
      wait_idle();
      check("sb_drained", 32'(q.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
